// File: rtl/eth_tx_pkt_buf.sv
// Store-and-forward packet buffer ahead of eth_tx: holds one whole packet, measures its length
// and ones'-complement sum, then replays it through the early-valid/ready handshake.
module eth_tx_pkt_buf #(
   parameter int DATA_W    = 16,
   parameter int KEEP_W    = DATA_W / 8,
   parameter int LEN_W     = $clog2(KEEP_W + 1),
   parameter int PKT_LEN_W = 16,
   parameter int DEPTH     = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid_i,
   input  logic [DATA_W-1:0]    in_data_i,
   input  logic [LEN_W-1:0]     in_len_i,
   input  logic                 in_last_i,
   input  logic                 in_cancel_i,
   output logic                 in_ready_o,
   output logic                 ovf_o,
   output logic                 app_early_v_o,
   input  logic                 app_ready_v_i,
   output logic                 app_valid_o,
   output logic [DATA_W-1:0]    app_data_o,
   output logic [LEN_W-1:0]     app_len_o,
   output logic                 app_last_o,
   output logic [PKT_LEN_W-1:0] app_pkt_len_o,
   output logic [15:0]          app_cs_o,
   output logic                 app_cancel_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW = $clog2(DEPTH + 1);

   typedef enum logic [2:0] {StIdle, StFill, StDrop, StHold, StSend} state_t;

   state_t               r_state, w_state_nxt;
   logic [PW-1:0]        r_wptr, w_wptr_nxt;
   logic [PW-1:0]        r_rptr, w_rptr_nxt;
   logic [PKT_LEN_W-1:0] r_cnt, w_cnt_nxt, w_cnt_add;
   logic [15:0]          r_sum, w_sum_nxt, w_sum_add;
   logic [LEN_W-1:0]     r_last_len, w_last_len_nxt;
   logic [DATA_W-1:0]    r_mem [DEPTH];
   logic                 w_accept, w_wr, w_ovf, w_clr, w_rd_last, w_send, w_show;

   // Adds each big-endian 16-bit lane pair with end-around carry; lanes >= len count as zero.
   function automatic logic [15:0] f_csum_add(input logic [15:0]       sum,
                                              input logic [DATA_W-1:0] data,
                                              input logic [LEN_W-1:0]  len);
      logic [15:0] acc;
      logic [16:0] tmp;
      logic [7:0]  hi, lo;
      acc = sum;
      for (int k = 0; k < KEEP_W / 2; k++) begin
         hi  = (2 * k < int'(len)) ? data[16*k +: 8] : 8'h00;
         lo  = (2 * k + 1 < int'(len)) ? data[16*k+8 +: 8] : 8'h00;
         tmp = {1'b0, acc} + {1'b0, hi, lo};
         acc = tmp[15:0] + {15'd0, tmp[16]};
      end
      return acc;
   endfunction

   assign in_ready_o = (r_state == StIdle) || (r_state == StFill) || (r_state == StDrop);
   assign w_accept   = in_valid_i & in_ready_o;
   assign w_cnt_add  = r_cnt + PKT_LEN_W'(in_len_i);
   assign w_sum_add  = f_csum_add(r_sum, in_data_i, in_len_i);
   assign w_rd_last  = (r_rptr == r_wptr - PW'(1));

   always_comb begin
      w_state_nxt    = r_state;
      w_wptr_nxt     = r_wptr;
      w_rptr_nxt     = r_rptr;
      w_cnt_nxt      = r_cnt;
      w_sum_nxt      = r_sum;
      w_last_len_nxt = r_last_len;
      w_wr           = 1'b0;
      w_ovf          = 1'b0;
      w_clr          = 1'b0;
      unique case (r_state)
         StIdle, StFill: begin
            if (in_cancel_i) begin
               w_clr       = 1'b1;
               w_state_nxt = StIdle;
            end else if (w_accept) begin
               if (r_wptr == PW'(DEPTH)) begin
                  w_ovf       = 1'b1;
                  w_clr       = 1'b1;
                  w_state_nxt = in_last_i ? StIdle : StDrop;
               end else begin
                  // An empty closing word carries no bytes, so it is not stored as a word.
                  w_wr        = (in_len_i != '0);
                  w_wptr_nxt  = w_wr ? r_wptr + PW'(1) : r_wptr;
                  w_cnt_nxt   = w_cnt_add;
                  w_sum_nxt   = w_sum_add;
                  w_state_nxt = StFill;
                  if (in_last_i) begin
                     w_last_len_nxt = w_wr ? in_len_i : LEN_W'(KEEP_W);
                     if (w_cnt_add == '0) begin
                        w_clr       = 1'b1;
                        w_state_nxt = StIdle;
                     end else begin
                        w_state_nxt = StHold;
                     end
                  end
               end
            end
         end
         StDrop: begin
            if (in_cancel_i || (w_accept && in_last_i)) begin
               w_clr       = 1'b1;
               w_state_nxt = StIdle;
            end
         end
         StHold: begin
            if (app_ready_v_i) begin
               w_rptr_nxt  = '0;
               w_state_nxt = StSend;
            end
         end
         StSend: begin
            w_rptr_nxt = r_rptr + PW'(1);
            if (w_rd_last) begin
               w_clr       = 1'b1;
               w_state_nxt = StIdle;
            end
         end
         default: begin
            w_clr       = 1'b1;
            w_state_nxt = StIdle;
         end
      endcase
      if (w_clr) begin
         w_wptr_nxt = '0;
         w_rptr_nxt = '0;
         w_cnt_nxt  = '0;
         w_sum_nxt  = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= StIdle;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_cnt      <= '0;
         r_sum      <= '0;
         r_last_len <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wptr     <= w_wptr_nxt;
         r_rptr     <= w_rptr_nxt;
         r_cnt      <= w_cnt_nxt;
         r_sum      <= w_sum_nxt;
         r_last_len <= w_last_len_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr[AW-1:0]] <= in_data_i;
   end

   // Outputs are decoded from state so an asynchronous reset clears them without a clock.
   assign w_send        = (r_state == StSend);
   assign w_show        = (r_state == StHold) || w_send;
   assign ovf_o         = w_ovf;
   assign app_early_v_o = (r_state == StHold);
   assign app_valid_o   = w_send;
   assign app_data_o    = w_send ? r_mem[r_rptr[AW-1:0]] : '0;
   assign app_len_o     = w_send ? (w_rd_last ? r_last_len : LEN_W'(KEEP_W)) : '0;
   assign app_last_o    = w_send & w_rd_last;
   assign app_pkt_len_o = w_show ? r_cnt : '0;
   assign app_cs_o      = w_show ? r_sum : '0;
   assign app_cancel_o  = 1'b0;

endmodule

// File: tb/tb_eth_tx_pkt_buf.sv
// Bench for eth_tx_pkt_buf: two instances (DEPTH 64 and 4) driven with directed and random
// packets, checked against a byte-queue model of length, checksum and replayed words.
module tb_eth_tx_pkt_buf;

   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        in_valid [2];
   logic        in_last  [2];
   logic        in_cancel[2];
   logic        app_ready[2];
   logic [15:0] in_data  [2];
   logic [1:0]  in_len   [2];
   logic        in_ready [2];
   logic        ovf      [2];
   logic        early_v  [2];
   logic        app_valid[2];
   logic        app_last [2];
   logic        app_cancel[2];
   logic [15:0] app_data [2];
   logic [15:0] pkt_len  [2];
   logic [15:0] cs       [2];
   logic [1:0]  app_len  [2];

   int n_checks = 0;
   int n_errors = 0;

   eth_tx_pkt_buf #(.DATA_W(16), .DEPTH(64)) u_dut0 (
      .clk(clk), .reset(rst),
      .in_valid_i(in_valid[0]), .in_data_i(in_data[0]), .in_len_i(in_len[0]),
      .in_last_i(in_last[0]), .in_cancel_i(in_cancel[0]), .in_ready_o(in_ready[0]),
      .ovf_o(ovf[0]), .app_early_v_o(early_v[0]), .app_ready_v_i(app_ready[0]),
      .app_valid_o(app_valid[0]), .app_data_o(app_data[0]), .app_len_o(app_len[0]),
      .app_last_o(app_last[0]), .app_pkt_len_o(pkt_len[0]), .app_cs_o(cs[0]),
      .app_cancel_o(app_cancel[0])
   );

   eth_tx_pkt_buf #(.DATA_W(16), .DEPTH(4)) u_dut1 (
      .clk(clk), .reset(rst),
      .in_valid_i(in_valid[1]), .in_data_i(in_data[1]), .in_len_i(in_len[1]),
      .in_last_i(in_last[1]), .in_cancel_i(in_cancel[1]), .in_ready_o(in_ready[1]),
      .ovf_o(ovf[1]), .app_early_v_o(early_v[1]), .app_ready_v_i(app_ready[1]),
      .app_valid_o(app_valid[1]), .app_data_o(app_data[1]), .app_len_o(app_len[1]),
      .app_last_o(app_last[1]), .app_pkt_len_o(pkt_len[1]), .app_cs_o(cs[1]),
      .app_cancel_o(app_cancel[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference checksum: sum all big-endian byte pairs, fold the carries once at the end.
   function automatic logic [15:0] ref_cs(input bq_t b);
      int unsigned total = 0;
      for (int i = 0; i < b.size(); i += 2)
         total += {16'h0, b[i], (i + 1 < b.size()) ? b[i+1] : 8'h00};
      while (total > 32'hFFFF) total = (total & 32'hFFFF) + (total >> 16);
      return total[15:0];
   endfunction

   function automatic bq_t rand_bytes(input int n);
      bq_t b;
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      return b;
   endfunction

   // Presents a packet word by word; cancel_at >= 0 aborts on that word and stops.
   task automatic drive_pkt(input int d, input bq_t b, input int cancel_at, input int max_gap);
      int nw;
      int depth;
      nw    = (b.size() + 1) / 2;
      depth = (d == 1) ? 4 : 64;
      for (int w = 0; w < nw; w++) begin
         repeat ($urandom_range(max_gap, 0)) @(negedge clk);
         in_valid[d]  = 1'b1;
         in_len[d]    = (2 * w + 1 < b.size()) ? 2'd2 : 2'd1;
         in_data[d]   = {(2 * w + 1 < b.size()) ? b[2*w+1] : 8'($urandom), b[2*w]};
         in_last[d]   = (w == nw - 1);
         in_cancel[d] = (w == cancel_at);
         #1;
         check("in_ready_fill", in_ready[d], 1);
         check("early_v_fill", early_v[d], 0);
         check("ovf", ovf[d], (w == depth) && (w != cancel_at));
         @(negedge clk);
         in_valid[d]  = 1'b0;
         in_last[d]   = 1'b0;
         in_cancel[d] = 1'b0;
         if (w == cancel_at) break;
      end
   endtask

   // Checks HOLD, grants after `hold` cycles, then checks every replayed word.
   task automatic expect_tx(input int d, input bq_t b, input int hold, input int abort_at);
      int          nw;
      int          len;
      logic [15:0] ecs, exp, mask;
      nw  = (b.size() + 1) / 2;
      ecs = ref_cs(b);
      check("early_v_rise", early_v[d], 1);
      check("pkt_len", pkt_len[d], b.size());
      check("cs", cs[d], ecs);
      check("in_ready_hold", in_ready[d], 0);
      for (int i = 0; i < hold; i++) begin
         in_valid[d] = 1'b1;
         in_data[d]  = 16'($urandom);
         in_len[d]   = 2'd2;
         in_last[d]  = 1'b1;
         @(negedge clk);
         check("early_v_hold", early_v[d], 1);
         check("pkt_len_hold", pkt_len[d], b.size());
         check("cs_hold", cs[d], ecs);
         check("in_ready_hold", in_ready[d], 0);
         check("valid_hold", app_valid[d], 0);
      end
      in_valid[d]  = 1'b0;
      in_last[d]   = 1'b0;
      app_ready[d] = 1'b1;
      @(negedge clk);
      app_ready[d] = 1'b0;
      for (int w = 0; w < nw; w++) begin
         if (w == abort_at) begin
            #2 rst = 1'b1;
            #1;
            check("rst_valid", app_valid[d], 0);
            check("rst_early", early_v[d], 0);
            check("rst_last", app_last[d], 0);
            check("rst_len", app_len[d], 0);
            check("rst_data", app_data[d], 0);
            check("rst_pkt_len", pkt_len[d], 0);
            check("rst_cs", cs[d], 0);
            check("rst_ready", in_ready[d], 1);
            return;
         end
         len  = (2 * w + 1 < b.size()) ? 2 : 1;
         mask = (len == 2) ? 16'hFFFF : 16'h00FF;
         exp  = {(len == 2) ? b[2*w+1] : 8'h00, b[2*w]};
         check("app_valid", app_valid[d], 1);
         check("app_len", app_len[d], len);
         check("app_last", app_last[d], w == nw - 1);
         check("app_data", app_data[d] & mask, exp & mask);
         check("pkt_len_send", pkt_len[d], b.size());
         check("cs_send", cs[d], ecs);
         @(negedge clk);
      end
      check("valid_after", app_valid[d], 0);
      check("in_ready_after", in_ready[d], 1);
      check("early_after", early_v[d], 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bq_t b;
      int  n;
      for (int d = 0; d < 2; d++) begin
         in_valid[d]  = 1'b0;
         in_last[d]   = 1'b0;
         in_cancel[d] = 1'b0;
         app_ready[d] = 1'b0;
         in_data[d]   = '0;
         in_len[d]    = '0;
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("reset_ready", in_ready[d], 1);
         check("reset_early", early_v[d], 0);
         check("reset_valid", app_valid[d], 0);
         check("reset_ovf", ovf[d], 0);
         check("reset_pkt_len", pkt_len[d], 0);
         check("reset_cs", cs[d], 0);
         check("reset_cancel", app_cancel[d], 0);
      end
      rst = 1'b0;
      @(negedge clk);

      // 19 bytes 0x01..0x13
      b.delete();
      for (int i = 1; i <= 19; i++) b.push_back(8'(i));
      drive_pkt(0, b, -1, 0);
      check("cs_19", cs[0], 16'h645A);
      expect_tx(0, b, 0, -1);

      // Carry fold
      b = '{8'hFF, 8'hFF, 8'h00, 8'h01};
      drive_pkt(0, b, -1, 0);
      check("cs_fold", cs[0], 16'h0001);
      expect_tx(0, b, 0, -1);

      // Grant withheld for 5 cycles
      b = rand_bytes(8);
      drive_pkt(0, b, -1, 1);
      expect_tx(0, b, 5, -1);

      // Cancel on the 3rd word, then a 4-byte packet alone
      b = rand_bytes(12);
      drive_pkt(0, b, 2, 0);
      repeat (3) begin
         check("early_after_cancel", early_v[0], 0);
         @(negedge clk);
      end
      b = rand_bytes(4);
      drive_pkt(0, b, -1, 0);
      expect_tx(0, b, 0, -1);

      // DEPTH=4 overflow with a 7-word packet, then a 2-word packet
      b = rand_bytes(14);
      drive_pkt(1, b, -1, 0);
      check("early_after_ovf", early_v[1], 0);
      @(negedge clk);
      check("early_after_ovf2", early_v[1], 0);
      b = rand_bytes(4);
      drive_pkt(1, b, -1, 0);
      expect_tx(1, b, 0, -1);

      // Reset during SEND on word 3 of 10, then a fresh packet
      b = rand_bytes(20);
      drive_pkt(0, b, -1, 0);
      expect_tx(0, b, 0, 2);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_ready", in_ready[0], 1);
      check("post_rst_early", early_v[0], 0);
      b = rand_bytes(15);
      drive_pkt(0, b, -1, 0);
      expect_tx(0, b, 1, -1);

      // Random packets
      repeat (30) begin
         b = rand_bytes($urandom_range(60, 1));
         drive_pkt(0, b, -1, 2);
         expect_tx(0, b, $urandom_range(3, 0), -1);
      end
      repeat (20) begin
         n = $urandom_range(12, 1);
         b = rand_bytes(n);
         drive_pkt(1, b, -1, 1);
         if ((n + 1) / 2 > 4) begin
            check("early_rand_ovf", early_v[1], 0);
            @(negedge clk);
         end else begin
            expect_tx(1, b, $urandom_range(2, 0), -1);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
